// File: rtl/arb_mux_n_pkg.sv
// Shared constants and helpers for the round-robin stream mux and its arbiter.
// Optional skid buffer in arb_mux_n is enabled with `define ARB_MUX_SKID_EN.
package arb_mux_n_pkg;

    localparam int WORD_WIDTH_DEF = 32;
    localparam int ARB_MUX_MAX_CH = 16;

    // Channel-id width; a 1-channel id still needs one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, and moves
// the pointer to just past the winner whenever a grant is taken.
module rr_arbiter
    import arb_mux_n_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int SEL_WIDTH = clog2_min1(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      req,
    input  logic                 advance,
    output logic [N_CH-1:0]      grant,
    output logic [SEL_WIDTH-1:0] grant_idx
);

    // Scan index wide enough to hold rr_ptr + offset before the modulo fold.
    localparam int IW = clog2_min1(ARB_MUX_MAX_CH) + 1;

    logic [SEL_WIDTH-1:0] rr_ptr;
    logic                 found;
    logic [IW-1:0]        idx;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = IW'(rr_ptr) + IW'(i);
            if (idx >= IW'(N_CH)) idx = idx - IW'(N_CH);
            if (!found && req[idx[SEL_WIDTH-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[SEL_WIDTH-1:0];
            end
        end
    end

    assign grant = found ? (N_CH'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == SEL_WIDTH'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel valid/ready stream mux with round-robin fairness and a registered output.
// `define ARB_MUX_SKID_EN adds one skid slot so in_ready no longer depends on out_ready.
module arb_mux_n
    import arb_mux_n_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int N_CH       = 4,
    parameter int SEL_WIDTH  = clog2_min1(N_CH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_CH-1:0][WORD_WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]                 in_valid,
    output logic [N_CH-1:0]                 in_ready,
    output logic [WORD_WIDTH-1:0]           out_data,
    output logic [SEL_WIDTH-1:0]            out_sel,
    output logic                            out_valid,
    input  logic                            out_ready
);

    logic [N_CH-1:0]       grant;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [WORD_WIDTH-1:0] sel_data;
    logic                  can_load;
    logic                  in_fire;
    logic                  out_fire;

    rr_arbiter #(
        .N_CH      (N_CH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (in_fire),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_data = in_data[grant_idx];
    assign in_ready = grant & {N_CH{can_load}};
    assign in_fire  = |(in_ready & in_valid);
    assign out_fire = out_valid & out_ready;

`ifdef ARB_MUX_SKID_EN
    logic                  skid_valid;
    logic [WORD_WIDTH-1:0] skid_data;
    logic [SEL_WIDTH-1:0]  skid_sel;

    // Output register plus one skid slot: accept whenever the slot is free,
    // which absorbs the one word that arrives after out_ready drops.
    assign can_load = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
        end else if (out_fire) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_sel    <= skid_sel;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_data <= sel_data;
                out_sel  <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid) begin
                out_data  <= sel_data;
                out_sel   <= grant_idx;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= sel_data;
                skid_sel   <= grant_idx;
                skid_valid <= 1'b1;
            end
        end
    end
`else
    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (in_fire) begin
            out_data  <= sel_data;
            out_sel   <= grant_idx;
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench for arb_mux_n (N_CH=4 main instance, N_CH=3 wrap instance).
// Works with and without ARB_MUX_SKID_EN.
module tb_arb_mux_n;

    localparam int N = 4;
    localparam int W = 32;
`ifdef ARB_MUX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } word_t;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0][W-1:0]  in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [W-1:0]         out_data;
    logic [1:0]           out_sel;
    logic                 out_valid;
    logic                 out_ready;

    logic [2:0][W-1:0]    in_data3;
    logic [2:0]           in_valid3;
    logic [2:0]           in_ready3;
    logic [W-1:0]         out_data3;
    logic [1:0]           out_sel3;
    logic                 out_valid3;
    logic                 out_ready3;

    word_t        q[$];
    int           ptr;
    int           wait_cnt[N];
    int           n_chk;
    int           n_pass;
    logic [N-1:0] acc;

    arb_mux_n #(.WORD_WIDTH(W), .N_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    arb_mux_n #(.WORD_WIDTH(W), .N_CH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Advance to the next negedge and drop valids the DUT accepted last cycle.
    task automatic drive_edge();
        @(negedge clk);
        in_valid = in_valid & ~acc;
        acc      = '0;
    endtask

    task automatic raise(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[k] && !in_valid[k]) begin
                in_valid[k] = 1'b1;
                in_data[k]  = $urandom;
            end
        end
    endtask

    // Sample the DUT mid-cycle, compare against the model, then update the
    // model with the transfers that the coming posedge will perform.
    task automatic check_cycle();
        logic [N-1:0] er;
        int           g;
        bit           can;
        word_t        w;
        #1;
        can = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
        g = -1;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (ptr + i) % N;
            if (g < 0 && in_valid[c]) g = c;
        end
        er = '0;
        if (g >= 0 && can) er[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_sel", 64'(out_sel), 64'(q[0].sel));
            chk("out_data", 64'(out_data), 64'(q[0].data));
            if (out_ready) w = q.pop_front();
        end
        if (er != '0) begin
            w.sel  = 2'(g);
            w.data = in_data[g];
            q.push_back(w);
            chk("starve", 64'(wait_cnt[g] <= N - 1), 64'(1));
            wait_cnt[g] = 0;
            for (int k = 0; k < N; k++)
                if (k != g && in_valid[k]) wait_cnt[k]++;
            ptr = (g + 1) % N;
        end
        acc = in_valid & in_ready;
    endtask

    task automatic model_reset();
        q.delete();
        ptr = 0;
        acc = '0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            drive_edge();
            out_ready = 1'b1;
            check_cycle();
            done = (q.size() == 0) && ((in_valid & ~acc) == '0);
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    initial begin
        logic [W-1:0] held;
        logic [1:0]   held_sel;
        int           extra;
        word_t        w;

        n_chk = 0; n_pass = 0;
        rst_n = 1'b0;
        in_valid = '0; in_data = '0; out_ready = 1'b0;
        in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;
        model_reset();
        #12;
        chk("rst_vld", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_sel", 64'(out_sel), 64'(0));
        chk("rst_rdy", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // N_CH=3: pointer wraps from 2 back to 0.
        @(negedge clk);
        in_valid3 = 3'b100; in_data3[2] = 32'h0000_0C02; out_ready3 = 1'b1;
        #1 chk("n3_gnt2", 64'(in_ready3), 64'(3'b100));
        @(negedge clk);
        in_valid3 = 3'b111; in_data3[2] = 32'h0000_0C12;
        #1 chk("n3_wrap", 64'(in_ready3), 64'(3'b001));
        chk("n3_sel", 64'(out_sel3), 64'(2));
        chk("n3_data", 64'(out_data3), 64'(32'h0000_0C02));
        @(negedge clk);
        in_valid3 = '0;

        // Single channel, then pointer skip from 3 to ch1.
        drive_edge();
        in_valid = 4'b0100; in_data[2] = 32'hDEADBEEF; out_ready = 1'b1;
        check_cycle();
        chk("t2_ready", 64'(in_ready), 64'(4'b0100));
        drive_edge();
        in_valid[1] = 1'b1; in_data[1] = $urandom;
        check_cycle();
        chk("t2_data", 64'(out_data), 64'(32'hDEADBEEF));
        chk("t2_sel", 64'(out_sel), 64'(2));
        chk("t2_vld", 64'(out_valid), 64'(1));
        chk("t5_skip", 64'(in_ready), 64'(4'b0010));
        drive_edge();
        raise('1);
        check_cycle();
        chk("t5_ptr", 64'(in_ready), 64'(4'b0100));

        // Back-pressure for 5 cycles.
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            drive_edge();
            raise('1);
            out_ready = 1'b0;
            check_cycle();
            if (i == 0) begin
                held = out_data; held_sel = out_sel;
            end else begin
                chk("t4_data", 64'(out_data), 64'(held));
                chk("t4_sel", 64'(out_sel), 64'(held_sel));
            end
            extra += $countones(in_ready);
        end
        chk("t4_extra", 64'(extra), 64'(SKID ? 1 : 0));
        drain("t4_drain", 40);

        // Async reset with a word in flight.
        drive_edge();
        raise('1); out_ready = 1'b1;
        check_cycle();
        drive_edge();
        out_ready = 1'b0;
        #1 chk("t1_pre", 64'(out_valid), 64'(1));
        #1 rst_n = 1'b0; in_valid = '0;
        #1;
        chk("t1_vld", 64'(out_valid), 64'(0));
        chk("t1_data", 64'(out_data), 64'(0));
        chk("t1_sel", 64'(out_sel), 64'(0));
        chk("t1_rdy", 64'(in_ready), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all channels continuously valid.
        for (int i = 0; i < 8; i++) begin
            drive_edge();
            raise('1); out_ready = 1'b1;
            check_cycle();
            chk("rr_gnt", 64'(in_ready), 64'(1) << (i % 4));
            if (i > 0) chk("rr_sel", 64'(out_sel), 64'((i - 1) % 4));
        end

        // Random valid/ready traffic.
        for (int c = 0; c < 10000; c++) begin
            logic [N-1:0] m;
            drive_edge();
            for (int k = 0; k < N; k++) m[k] = ($urandom_range(0, 2) == 0);
            raise(m);
            out_ready = ($urandom_range(0, 3) != 0);
            check_cycle();
        end
        drain("final_drain", 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
